// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the burst memory controller.
// Imported by the controller, its host interface and the bench.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_BURST_MAX = 8;
   localparam int DEF_T_SETUP   = 2;
   localparam int DEF_T_ACCESS  = 3;
   localparam int DEF_T_RECOVER = 1;

   // Wide enough to hold the longest phase length minus one.
   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/burst_mem_ctrl_if.sv
// Host-side request, write-data and read-data channels of the
// burst memory controller; master = host, slave = controller.
interface burst_mem_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = $clog2(DEF_BURST_MAX)
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;

   modport master (
      output req_valid, req_we, req_addr, req_len,
      output wr_valid, wr_data,
      input  req_ready, wr_ready, rd_valid, rd_data,
      input  busy, done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_len,
      input  wr_valid, wr_data,
      output req_ready, wr_ready, rd_valid, rd_data,
      output busy, done
   );

endinterface

// File: rtl/mem_phase_timer.sv
// Loadable down-counter with terminal-count flag, shared by the
// setup, access and recovery phases of the controller.
module mem_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/burst_mem_ctrl.sv
// Burst controller for an asynchronous SRAM-style device: sequential
// beat addresses, CS/WE/OE strobes with programmable phase timing.
module burst_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int BURST_MAX = DEF_BURST_MAX,
   parameter int T_SETUP   = DEF_T_SETUP,
   parameter int T_ACCESS  = DEF_T_ACCESS,
   parameter int T_RECOVER = DEF_T_RECOVER
) (
   input  logic              clk,
   input  logic              rst_n,
   burst_mem_ctrl_if.slave   host,
   output logic              mem_cs_n,
   output logic              mem_we_n,
   output logic              mem_oe_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int LEN_W = $clog2(BURST_MAX);
   localparam int CW    = cnt_w(T_SETUP, T_ACCESS, T_RECOVER);

   state_t           state;
   state_t           nxt;
   logic             we_q;
   logic [LEN_W-1:0] beats;
   logic             tc;
   logic             load;
   logic [CW-1:0]    load_val;
   logic             stall;

   assign host.req_ready = (state == IDLE);
   assign stall = we_q && !host.wr_valid;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (host.req_valid) nxt = SETUP;
         SETUP:   if (tc && !stall) nxt = ACCESS;
         ACCESS:  if (tc) nxt = RECOVER;
         RECOVER: if (tc) nxt = (beats == '0) ? IDLE : SETUP;
         default: nxt = IDLE;
      endcase
   end

   // Every phase change reloads the shared timer with its length - 1.
   assign load = (nxt != state);

   always_comb begin
      load_val = '0;
      unique case (nxt)
         SETUP:   load_val = CW'(T_SETUP - 1);
         ACCESS:  load_val = CW'(T_ACCESS - 1);
         RECOVER: load_val = CW'(T_RECOVER - 1);
         default: load_val = '0;
      endcase
   end

   mem_phase_timer #(
      .W (CW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .tc       (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         beats         <= '0;
         mem_cs_n      <= 1'b1;
         mem_we_n      <= 1'b1;
         mem_oe_n      <= 1'b1;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         host.rd_data  <= '0;
         host.rd_valid <= 1'b0;
         host.wr_ready <= 1'b0;
         host.done     <= 1'b0;
         host.busy     <= 1'b0;
      end else begin
         state         <= nxt;
         host.rd_valid <= 1'b0;
         host.wr_ready <= 1'b0;
         host.done     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (host.req_valid) begin
                  we_q      <= host.req_we;
                  mem_addr  <= host.req_addr;
                  beats     <= host.req_len;
                  host.busy <= 1'b1;
                  mem_cs_n  <= 1'b0;
               end
            end
            SETUP: begin
               if (tc && !stall) begin
                  if (we_q) begin
                     mem_we_n      <= 1'b0;
                     host.wr_ready <= 1'b1;
                     mem_wdata     <= host.wr_data;
                  end else begin
                     mem_oe_n <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (tc) begin
                  mem_cs_n <= 1'b1;
                  mem_we_n <= 1'b1;
                  mem_oe_n <= 1'b1;
                  if (!we_q) begin
                     host.rd_data  <= mem_rdata;
                     host.rd_valid <= 1'b1;
                  end
               end
            end
            RECOVER: begin
               if (tc) begin
                  if (beats == '0) begin
                     host.done <= 1'b1;
                     host.busy <= 1'b0;
                  end else begin
                     beats    <= beats - LEN_W'(1);
                     mem_addr <= mem_addr + ADDR_W'(1);
                     mem_cs_n <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Bench for burst_mem_ctrl: vector table, scoreboard of beats, and
// hand sequences for stall, back-to-back, abort and fast timing.
module tb_burst_mem_ctrl;
   import mem_ctrl_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int LW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   burst_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) h ();
   burst_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(2)) h2 ();

   logic          cs_n, we_n, oe_n;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mwdata, mrdata;
   logic          cs2_n, we2_n, oe2_n;
   logic [AW-1:0] maddr2;
   logic [DW-1:0] mwdata2, mrdata2;

   assign mrdata  = {~maddr, maddr};
   assign mrdata2 = '0;

   burst_mem_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .host      (h),
      .mem_cs_n  (cs_n),
      .mem_we_n  (we_n),
      .mem_oe_n  (oe_n),
      .mem_addr  (maddr),
      .mem_wdata (mwdata),
      .mem_rdata (mrdata)
   );

   burst_mem_ctrl #(
      .BURST_MAX (4),
      .T_SETUP   (1),
      .T_ACCESS  (1),
      .T_RECOVER (1)
   ) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .host      (h2),
      .mem_cs_n  (cs2_n),
      .mem_we_n  (we2_n),
      .mem_oe_n  (oe2_n),
      .mem_addr  (maddr2),
      .mem_wdata (mwdata2),
      .mem_rdata (mrdata2)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   logic [DW-1:0]    rd_q[$];
   logic [AW-1:0]    ra_q[$];
   logic [AW+DW-1:0] wr_q[$];
   logic [DW-1:0]    wq[$];
   logic [AW+DW-1:0] we_exp;
   logic [AW-1:0]    ra_exp;
   logic [DW-1:0]    rd_exp;

   int   cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0;
   int   cs_cnt = 0, we_cnt = 0, oe_cnt = 0, wrr_cnt = 0;
   int   oe_falls = 0, last_rd = -1, hold_n = 0;
   logic busy_prev = 1'b0, we_prev = 1'b1, oe_prev = 1'b1;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (h.busy && !busy_prev) begin
         acc_cyc = cyc;
         last_rd = -1;
      end
      busy_prev = h.busy;
      if (h.done) begin
         done_cyc = cyc;
         done_cnt++;
      end
      chk("ready_vs_busy", 64'(h.req_ready), 64'(!h.busy));
      if (!cs_n) cs_cnt++;
      if (!we_n) we_cnt++;
      if (!oe_n) oe_cnt++;
      if (!we_n || !oe_n) chk("strobe_without_cs", 64'(cs_n), 0);
      if (!we_n && we_prev) begin
         we_exp = (wr_q.size() > 0) ? wr_q.pop_front() : 'x;
         chk("write_beat", {maddr, mwdata}, 64'(we_exp));
      end
      if (!oe_n && oe_prev) begin
         oe_falls++;
         ra_exp = (ra_q.size() > 0) ? ra_q.pop_front() : 'x;
         chk("read_addr", 64'(maddr), 64'(ra_exp));
      end
      if (h.rd_valid) begin
         rd_exp = (rd_q.size() > 0) ? rd_q.pop_front() : 'x;
         chk("rd_data", 64'(h.rd_data), 64'(rd_exp));
         if (last_rd >= 0) chk("rd_gap", 64'(cyc - last_rd), 6);
         last_rd = cyc;
      end
      we_prev = we_n;
      oe_prev = oe_n;
      if (h.wr_ready) begin
         wrr_cnt++;
         if (wq.size() > 0) void'(wq.pop_front());
      end
      if (hold_n > 0) begin
         hold_n--;
         h.wr_valid = 1'b0;
      end else begin
         h.wr_valid = (wq.size() > 0);
      end
      h.wr_data = (wq.size() > 0) ? wq[0] : '0;
   end

   int            cyc2 = 0, acc2 = 0, done2 = 0, done2_cnt = 0, d2cnt = 0;
   logic          busy2_prev = 1'b0, we2_prev = 1'b1;
   logic [AW-1:0] a2_q[$];
   logic [DW-1:0] d2_q[$];
   int            t2_q[$];

   always @(posedge clk) begin
      #1;
      cyc2++;
      if (h2.busy && !busy2_prev) acc2 = cyc2;
      busy2_prev = h2.busy;
      if (h2.done) begin
         done2 = cyc2;
         done2_cnt++;
      end
      if (!we2_n && we2_prev) begin
         a2_q.push_back(maddr2);
         d2_q.push_back(mwdata2);
         t2_q.push_back(cyc2);
      end
      we2_prev = we2_n;
      if (h2.wr_ready) d2cnt++;
      h2.wr_valid = 1'b1;
      h2.wr_data = 32'hC0DE_0000 + DW'(d2cnt);
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      int            len;
      logic [DW-1:0] wbase;
      int            stall;
      int            lat;
      int            cs;
      int            wen;
      int            oen;
      int            wrr;
   } vec_t;

   vec_t tbl[5];

   task automatic push_exp(input logic we, input logic [AW-1:0] a,
                           input int len, input logic [DW-1:0] wb);
      logic [AW-1:0] ab;
      for (int b = 0; b <= len; b++) begin
         ab = a + AW'(b);
         if (we) begin
            wr_q.push_back({ab, wb + DW'(b)});
            wq.push_back(wb + DW'(b));
         end else begin
            ra_q.push_back(ab);
            rd_q.push_back({~ab, ab});
         end
      end
   endtask

   task automatic wait_done(input string nm);
      int  n0;
      bit  ok;
      n0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done_cnt != n0) begin
            ok = 1'b1;
            break;
         end
      end
      chk(nm, 64'(ok), 1);
   endtask

   task automatic wait_busy(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (h.busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(nm, 64'(ok), 1);
   endtask

   task automatic run_row(input vec_t v);
      @(negedge clk);
      cs_cnt  = 0;
      we_cnt  = 0;
      oe_cnt  = 0;
      wrr_cnt = 0;
      push_exp(v.we, v.addr, v.len, v.wbase);
      hold_n = (v.stall > 0) ? v.stall + 1 : 0;
      h.req_valid = 1'b1;
      h.req_we    = v.we;
      h.req_addr  = v.addr;
      h.req_len   = LW'(v.len);
      @(negedge clk);
      h.req_valid = 1'b0;
      chk("accepted_busy", 64'(h.busy), 1);
      wait_done("row_done");
      chk("row_latency", 64'(done_cyc - acc_cyc), 64'(v.lat));
      chk("row_cs_cycles", 64'(cs_cnt), 64'(v.cs));
      chk("row_we_cycles", 64'(we_cnt), 64'(v.wen));
      chk("row_oe_cycles", 64'(oe_cnt), 64'(v.oen));
      chk("row_wr_ready", 64'(wrr_cnt), 64'(v.wrr));
   endtask

   int d1, nd, n0;
   bit ok;

   initial begin
      h.req_valid  = 1'b0;
      h.req_we     = 1'b0;
      h.req_addr   = '0;
      h.req_len    = '0;
      h2.req_valid = 1'b0;
      h2.req_we    = 1'b0;
      h2.req_addr  = '0;
      h2.req_len   = '0;

      tbl[0] = '{1'b1, 16'h0010, 0, 32'hDEAD_BEEF, 0, 6, 5, 3, 0, 1};
      tbl[1] = '{1'b0, 16'hFFFE, 3, 32'h0, 0, 24, 20, 0, 12, 0};
      tbl[2] = '{1'b1, 16'h0100, 1, 32'h1111_0000, 4, 16, 14, 6, 0, 2};
      tbl[3] = '{1'b1, 16'hFFFF, 7, 32'hA000_0000, 0, 48, 40, 24, 0, 8};
      tbl[4] = '{1'b0, 16'h1234, 7, 32'h0, 0, 48, 40, 0, 24, 0};

      repeat (2) @(negedge clk);
      chk("rst_cs_n", 64'(cs_n), 1);
      chk("rst_we_n", 64'(we_n), 1);
      chk("rst_oe_n", 64'(oe_n), 1);
      chk("rst_addr", 64'(maddr), 0);
      chk("rst_wdata", 64'(mwdata), 0);
      chk("rst_rd_data", 64'(h.rd_data), 0);
      chk("rst_flags", {h.rd_valid, h.wr_ready, h.done, h.busy}, 0);
      chk("rst_req_ready", 64'(h.req_ready), 1);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_row(tbl[i]);

      // Second request held on req_valid while the first is in flight.
      @(negedge clk);
      push_exp(1'b1, 16'h0200, 0, 32'h2222_0000);
      h.req_valid = 1'b1;
      h.req_we    = 1'b1;
      h.req_addr  = 16'h0200;
      h.req_len   = '0;
      wait_busy("b2b_first_busy");
      push_exp(1'b0, 16'h0300, 1, 32'h0);
      h.req_we   = 1'b0;
      h.req_addr = 16'h0300;
      h.req_len  = LW'(1);
      n0 = done_cnt;
      wait_done("b2b_first_done");
      d1 = done_cyc;
      wait_busy("b2b_second_busy");
      h.req_valid = 1'b0;
      chk("b2b_accept_gap", 64'(acc_cyc - d1), 1);
      wait_done("b2b_second_done");
      chk("b2b_second_lat", 64'(done_cyc - acc_cyc), 12);
      chk("b2b_done_count", 64'(done_cnt - n0), 2);

      // Abort a 4-beat read during the access phase of its third beat.
      @(negedge clk);
      n0 = oe_falls;
      push_exp(1'b0, 16'h0400, 3, 32'h0);
      h.req_valid = 1'b1;
      h.req_we    = 1'b0;
      h.req_addr  = 16'h0400;
      h.req_len   = LW'(3);
      @(negedge clk);
      h.req_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (oe_falls == n0 + 3) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("abort_reach_beat2", 64'(ok), 1);
      chk("abort_in_access", 64'(oe_n), 0);
      nd = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_strobes", {cs_n, we_n, oe_n}, 3'b111);
      chk("abort_busy", 64'(h.busy), 0);
      chk("abort_ready", 64'(h.req_ready), 1);
      chk("abort_addr", 64'(maddr), 0);
      chk("abort_pending_reads", 64'(rd_q.size()), 2);
      rd_q.delete();
      ra_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(nd));
      run_row(tbl[0]);

      // Fast-timing instance: 3-cycle beats, four consecutive writes.
      @(negedge clk);
      h2.req_valid = 1'b1;
      h2.req_we    = 1'b1;
      h2.req_addr  = 16'h0040;
      h2.req_len   = 2'd3;
      @(negedge clk);
      h2.req_valid = 1'b0;
      n0 = done2_cnt;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done2_cnt != n0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("fast_done", 64'(ok), 1);
      chk("fast_latency", 64'(done2 - acc2), 12);
      chk("fast_beats", 64'(a2_q.size()), 4);
      for (int i = 0; i < 4 && i < a2_q.size(); i++) begin
         chk("fast_addr", 64'(a2_q[i]), 64'(16'h0040 + AW'(i)));
         chk("fast_data", 64'(d2_q[i]), 64'(32'hC0DE_0000 + DW'(i)));
         if (i > 0) chk("fast_period", 64'(t2_q[i] - t2_q[i-1]), 3);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 64'(rd_q.size() + ra_q.size() + wr_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
